bpred_update_queue: RTL and testbench

BPRED_UPDATE_QUEUE -- requirements
Module: bpred_update_queue

---
 rtl/bpred_update_queue_pkg.sv | 20 ++
 rtl/bpred_update_queue_if.sv | 31 +++
 rtl/bpred_update_queue_fifo.sv | 68 ++++++
 rtl/bpred_update_queue.sv | 76 +++++++
 tb/tb_bpred_update_queue.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bpred_update_queue_pkg.sv
// Shared types and default sizes for the branch-predictor update queue.
// Build option: BPRED_GSHARE_EN -- when defined, each queue entry also
// carries the global history that was current when the branch was fetched.
package bpred_pkg;

  localparam int BPRED_WIDTH = 8;
  localparam int QUEUE_DEPTH = 4;

  typedef logic [BPRED_WIDTH-1:0] idx_t;

  // One in-flight predicted branch, oldest at the FIFO head.
  typedef struct packed {
    idx_t index;
`ifdef BPRED_GSHARE_EN
    idx_t ghr;
`endif
    logic prediction;
  } entry_t;

endpackage

// File: rtl/bpred_update_queue_if.sv
// Fetch / resolve / counter-table signal bundle for bpred_update_queue.
// master: the fetch + ALU side driving it; slave: the update queue itself.
interface bpred_update_queue_if import bpred_pkg::*; ();

  logic i_Fetch_Valid;
  idx_t i_Fetch_PC;
  logic i_Fetch_Prediction;
  logic o_Fetch_Ready;
  logic i_Resolve_Valid;
  logic i_ALU_Branch_Outcome;
  idx_t o_Table_Index;
  logic o_Table_Enable;
  logic o_Table_Outcome;
  logic o_Mispredict;
  idx_t o_GHR;

  modport master (
    output i_Fetch_Valid, i_Fetch_PC, i_Fetch_Prediction,
    output i_Resolve_Valid, i_ALU_Branch_Outcome,
    input  o_Fetch_Ready, o_Table_Index, o_Table_Enable,
    input  o_Table_Outcome, o_Mispredict, o_GHR
  );

  modport slave (
    input  i_Fetch_Valid, i_Fetch_PC, i_Fetch_Prediction,
    input  i_Resolve_Valid, i_ALU_Branch_Outcome,
    output o_Fetch_Ready, o_Table_Index, o_Table_Enable,
    output o_Table_Outcome, o_Mispredict, o_GHR
  );

endinterface

// File: rtl/bpred_update_queue_fifo.sv
// bpred_fifo: in-order storage of in-flight branch entries.
// Depth must be a power of two so the pointers wrap by natural overflow.
// Flush beats push/pop; entry payloads are not reset, only the occupancy.
module bpred_fifo import bpred_pkg::*; #(
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   push_i,
  input  entry_t push_entry_i,
  input  logic   pop_i,
  input  logic   flush_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Next pointer/occupancy values; a flush empties the queue outright.
  always_comb begin
    do_push  = push_i & ~full_o & ~flush_i;
    do_pop   = pop_i & ~empty_o & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload write at the tail slot.
  always_ff @(posedge clk_i) begin
    if (do_push && rst_n_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/bpred_update_queue.sv
// bpred_update_queue: tracks predicted branches between fetch and resolve,
// drives counter-table updates and raises a one-cycle flush on mispredict.
// Build option: BPRED_GSHARE_EN -- gshare indexing (PC ^ GHR) with a
// speculative global history; otherwise the index is the PC and GHR is 0.
module bpred_update_queue #(
  parameter int QUEUE_DEPTH = bpred_pkg::QUEUE_DEPTH
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  bpred_update_queue_if.slave   bus
);
  import bpred_pkg::*;

  localparam int W = BPRED_WIDTH;

  entry_t         push_entry, head;
  logic           full, empty;
  logic [W-1:0]   ghr_q, ghr_d;
  logic [W-1:0]   lookup_index;
  logic           mispredict_q, mispredict_d;
  logic           resolve_fire, fetch_ready, push;

  bpred_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk_i        (i_Clk),
    .rst_n_i      (i_Reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (resolve_fire),
    .flush_i      (mispredict_d),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty)
  );

  // Handshake, lookup index, entry to push and next global history.
  always_comb begin
    resolve_fire = i_Reset & bus.i_Resolve_Valid & ~empty;
    mispredict_d = resolve_fire & (bus.i_ALU_Branch_Outcome != head.prediction);
    fetch_ready  = i_Reset & ~full & ~bus.i_Resolve_Valid & ~mispredict_q;
    push         = bus.i_Fetch_Valid & fetch_ready;
    push_entry   = '0;
`ifdef BPRED_GSHARE_EN
    lookup_index   = bus.i_Fetch_PC ^ ghr_q;
    push_entry.ghr = ghr_q;
    ghr_d          = ghr_q;
    if (mispredict_d)
      ghr_d = {head.ghr[W-2:0], bus.i_ALU_Branch_Outcome};
    else if (push)
      ghr_d = {ghr_q[W-2:0], bus.i_Fetch_Prediction};
`else
    lookup_index = bus.i_Fetch_PC;
    ghr_d        = '0;
`endif
    push_entry.index      = lookup_index;
    push_entry.prediction = bus.i_Fetch_Prediction;
  end

  // History and mispredict-pulse registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      ghr_q        <= '0;
      mispredict_q <= 1'b0;
    end else begin
      ghr_q        <= ghr_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign bus.o_Fetch_Ready   = fetch_ready;
  assign bus.o_Table_Enable  = resolve_fire;
  assign bus.o_Table_Index   = resolve_fire ? head.index : lookup_index;
  assign bus.o_Table_Outcome = bus.i_ALU_Branch_Outcome;
  assign bus.o_Mispredict    = mispredict_q;
  assign bus.o_GHR           = ghr_q;

endmodule

// File: tb/tb_bpred_update_queue.sv
// Directed bench for bpred_update_queue with a scoreboard of in-flight branches.
// Expectations follow BPRED_GSHARE_EN the same way the design build does.
module tb_bpred_update_queue;
  import bpred_pkg::*;

  localparam int D = QUEUE_DEPTH;
  localparam int W = BPRED_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bpred_update_queue_if bus_if ();

  bpred_update_queue dut (
    .i_Clk   (clk),
    .i_Reset (rst_n),
    .bus     (bus_if)
  );

  typedef struct {
    logic [W-1:0] idx;
    logic [W-1:0] ghr;
    logic         pred;
  } sb_t;

  sb_t          sb_q[$];
  logic [W-1:0] ghr_m;
  logic         misp_m;
  int           checks = 0;
  int           fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_lookup(input logic [W-1:0] pc);
`ifdef BPRED_GSHARE_EN
    return pc ^ ghr_m;
`else
    return pc;
`endif
  endfunction

  task automatic drive_idle();
    bus_if.i_Fetch_Valid   = 1'b0;
    bus_if.i_Resolve_Valid = 1'b0;
  endtask

  task automatic post_checks(input string tag);
    chk({tag, "_ghr"}, bus_if.o_GHR, ghr_m);
    chk({tag, "_mispredict"}, bus_if.o_Mispredict, misp_m);
  endtask

  task automatic do_fetch(input logic [W-1:0] pc, input logic pred);
    logic exp_ready;
    sb_t  e;
    bus_if.i_Fetch_Valid      = 1'b1;
    bus_if.i_Fetch_PC         = pc;
    bus_if.i_Fetch_Prediction = pred;
    #1;
    exp_ready = (sb_q.size() < D) && !misp_m;
    chk("fetch_ready", bus_if.o_Fetch_Ready, exp_ready);
    chk("lookup_index", bus_if.o_Table_Index, exp_lookup(pc));
    chk("fetch_no_enable", bus_if.o_Table_Enable, 1'b0);
    @(posedge clk); #1;
    if (exp_ready) begin
      e.idx  = exp_lookup(pc);
      e.ghr  = ghr_m;
      e.pred = pred;
      sb_q.push_back(e);
`ifdef BPRED_GSHARE_EN
      ghr_m = {ghr_m[W-2:0], pred};
`endif
    end
    misp_m = 1'b0;
    drive_idle();
    post_checks("fetch");
  endtask

  task automatic do_resolve(input logic outcome);
    logic busy;
    sb_t  h;
    bus_if.i_Resolve_Valid      = 1'b1;
    bus_if.i_ALU_Branch_Outcome = outcome;
    #1;
    busy = (sb_q.size() > 0);
    chk("resolve_enable", bus_if.o_Table_Enable, busy);
    chk("resolve_blocks_fetch", bus_if.o_Fetch_Ready, 1'b0);
    if (busy) begin
      h = sb_q[0];
      chk("update_index", bus_if.o_Table_Index, h.idx);
      chk("update_outcome", bus_if.o_Table_Outcome, outcome);
    end
    @(posedge clk); #1;
    misp_m = 1'b0;
    if (busy) begin
      h = sb_q.pop_front();
      if (h.pred != outcome) begin
        sb_q.delete();
        misp_m = 1'b1;
`ifdef BPRED_GSHARE_EN
        ghr_m = {h.ghr[W-2:0], outcome};
`endif
      end
    end
    drive_idle();
    post_checks("resolve");
  endtask

  task automatic do_idle();
    @(posedge clk); #1;
    misp_m = 1'b0;
    post_checks("idle");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.i_Fetch_Valid   = 1'b1;
    bus_if.i_Resolve_Valid = 1'b1;
    #1;
    chk("reset_ready", bus_if.o_Fetch_Ready, 1'b0);
    chk("reset_enable", bus_if.o_Table_Enable, 1'b0);
    @(posedge clk); #1;
    sb_q.delete();
    ghr_m  = '0;
    misp_m = 1'b0;
    post_checks("reset");
    drive_idle();
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", bus_if.o_Fetch_Ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ghr_m = '0;
    misp_m = 1'b0;
    bus_if.i_Fetch_PC           = '0;
    bus_if.i_Fetch_Prediction   = 1'b0;
    bus_if.i_ALU_Branch_Outcome = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    do_reset();

    // First fetch after reset, then a correct resolve and an empty resolve.
    do_fetch(8'h05, 1'b1);
`ifdef BPRED_GSHARE_EN
    chk("ghr_first_fetch", bus_if.o_GHR, 8'h01);
`else
    chk("ghr_first_fetch", bus_if.o_GHR, 8'h00);
`endif
    do_resolve(1'b1);
    do_resolve(1'b0);
    do_idle();

    // Fill to capacity; the extra fetch must be refused.
    for (int i = 0; i < D; i++)
      do_fetch(W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    #1;
    chk("full_ready", bus_if.o_Fetch_Ready, 1'b0);
    do_fetch(8'hAA, 1'b1);
    for (int i = 0; i < D; i++) do_resolve(sb_q[0].pred);
    do_resolve(1'b1);

    // Single mispredict from a clean history.
    do_reset();
    do_fetch(8'h03, 1'b1);
    do_resolve(1'b0);
    chk("ghr_after_flush", bus_if.o_GHR, 8'h00);
    do_idle();
    do_resolve(1'b1);

    // Three in flight, oldest resolved correctly, then drain.
    do_fetch(8'h11, 1'b1);
    do_fetch(8'h22, 1'b0);
    do_fetch(8'h33, 1'b1);
    do_resolve(1'b1);
    #1;
    chk("ready_after_pop", bus_if.o_Fetch_Ready, 1'b1);
    do_resolve(1'b0);
    do_resolve(1'b1);
    do_resolve(1'b0);

    // Mispredict with younger entries queued behind the head.
    do_fetch(8'h40, 1'b0);
    do_fetch(8'h41, 1'b1);
    do_fetch(8'h42, 1'b0);
    do_resolve(1'b0);
    do_resolve(1'b0);
    do_fetch(8'h50, 1'b1);
    do_resolve(1'b1);

    // Reset while entries are in flight.
    do_fetch(8'h61, 1'b1);
    do_fetch(8'h62, 1'b1);
    do_fetch(8'h63, 1'b0);
    do_reset();
    do_resolve(1'b1);

    // Mixed traffic exercising pointer wrap and random mispredicts.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0 && sb_q.size() < D)
        do_fetch(W'($urandom), 1'($urandom_range(0, 1)));
      else
        do_resolve(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
